// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller: writeback source codes,
// forwarding selects and the LSU-wait FSM states.
package hazard_pkg;

    // Writeback source encodings carried down the pipe in wb_sel*.
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // EX-stage operand source select.
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_e;

    // LSU-wait FSM states.
    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_RELEASE
    } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master: the pipeline datapath (drives indices/controls, receives stall/flush/fwd).
// slave:  hazard_ctrl.
interface hazard_ctrl_if;

    logic [4:0] rs1_addrD;
    logic [4:0] rs2_addrD;
    logic [4:0] rs1_addrE;
    logic [4:0] rs2_addrE;
    logic [4:0] rd_addrE;
    logic       rd_wrenE;
    logic [1:0] wb_selE;
    logic       pc_selE;
    logic [4:0] rd_addrM;
    logic       rd_wrenM;
    logic [4:0] rd_addrW;
    logic       rd_wrenW;
    logic       lsu_req_M;
    logic       lsu_ack_M;

    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       StallM;
    logic       FlushD;
    logic       FlushE;
    logic       FlushW;
    logic [1:0] fwd_a_selE;
    logic [1:0] fwd_b_selE;

    modport master (
        output rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE,
        output rd_addrE, rd_wrenE, wb_selE, pc_selE,
        output rd_addrM, rd_wrenM, rd_addrW, rd_wrenW,
        output lsu_req_M, lsu_ack_M,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW,
        input  fwd_a_selE, fwd_b_selE
    );

    modport slave (
        input  rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE,
        input  rd_addrE, rd_wrenE, wb_selE, pc_selE,
        input  rd_addrM, rd_wrenM, rd_addrW, rd_wrenW,
        input  lsu_req_M, lsu_ack_M,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW,
        output fwd_a_selE, fwd_b_selE
    );

endinterface

// File: rtl/hazard_fwd_unit.sv
// Forward select for one EX-stage operand. MEM-stage result is the youngest
// and wins over WB; x0 is never forwarded.
module hazard_fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs_addrE,
    input  logic [4:0] rd_addrM,
    input  logic       rd_wrenM,
    input  logic [4:0] rd_addrW,
    input  logic       rd_wrenW,
    output fwd_sel_e   fwd_sel
);

    // Pick the youngest in-flight producer of rs_addrE.
    always_comb begin
        fwd_sel = FWD_RF;
        if (rd_wrenM && (rd_addrM != 5'd0) && (rd_addrM == rs_addrE)) begin
            fwd_sel = FWD_MEM;
        end else if (rd_wrenW && (rd_addrW != 5'd0) && (rd_addrW == rs_addrE)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: sole driver of Stall*/Flush* and EX forwarding
// selects. LSU-wait FSM bounds the freeze to MEM_TIMEOUT cycles, then releases
// the pipe and raises the sticky o_mem_err.
// Optional feature macro: HAZARD_PERF_CNT_EN (saturating stall/flush counters).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    hazard_ctrl_if.slave  hz,
    output logic          o_mem_err,
    output logic [31:0]   o_stall_cnt,
    output logic [31:0]   o_flush_cnt
);

    localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_e          state, state_nxt;
    logic [CW-1:0]   wait_cnt, wait_cnt_nxt, wait_inc;
    logic            err_set;

    logic            mem_pend;
    logic            mem_wait;
    logic            load_use;
    logic            redirect;
    fwd_sel_e        fwd_a, fwd_b;

    hazard_fwd_unit u_fwd_a (
        .rs_addrE (hz.rs1_addrE),
        .rd_addrM (hz.rd_addrM),
        .rd_wrenM (hz.rd_wrenM),
        .rd_addrW (hz.rd_addrW),
        .rd_wrenW (hz.rd_wrenW),
        .fwd_sel  (fwd_a)
    );

    hazard_fwd_unit u_fwd_b (
        .rs_addrE (hz.rs2_addrE),
        .rd_addrM (hz.rd_addrM),
        .rd_wrenM (hz.rd_wrenM),
        .rd_addrW (hz.rd_addrW),
        .rd_wrenW (hz.rd_wrenW),
        .fwd_sel  (fwd_b)
    );

    // Hazard conditions; redirect is masked while frozen so a pending branch
    // stays held in EX and is applied the cycle the freeze drops.
    always_comb begin
        mem_pend = hz.lsu_req_M && !hz.lsu_ack_M;
        mem_wait = mem_pend && (state != S_RELEASE);
        load_use = (hz.wb_selE == WB_MEM) && hz.rd_wrenE && (hz.rd_addrE != 5'd0) &&
                   ((hz.rd_addrE == hz.rs1_addrD) || (hz.rd_addrE == hz.rs2_addrD));
        redirect = hz.pc_selE && !mem_wait;
    end

    // FSM state, wait counter and sticky error register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_RUN;
            wait_cnt  <= '0;
            o_mem_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (err_set) begin
                o_mem_err <= 1'b1;
            end
        end
    end

    // Next state: wait_cnt holds the number of frozen cycles already spent,
    // so the release is decided on the cycle that completes the MEM_TIMEOUT-th.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        err_set      = 1'b0;
        wait_inc     = (state == S_RUN) ? CW'(1) : wait_cnt + CW'(1);
        case (state)
            S_RUN, S_WAIT: begin
                if (mem_pend) begin
                    if (wait_inc == CW'(MEM_TIMEOUT)) begin
                        state_nxt    = S_RELEASE;
                        wait_cnt_nxt = '0;
                        err_set      = 1'b1;
                    end else begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = wait_inc;
                    end
                end else begin
                    state_nxt    = S_RUN;
                    wait_cnt_nxt = '0;
                end
            end
            S_RELEASE: begin
                if (!hz.lsu_req_M || hz.lsu_ack_M) begin
                    state_nxt = S_RUN;
                end
            end
            default: begin
                state_nxt    = S_RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Stall/flush/forward outputs by priority; held at zero while in reset.
    always_comb begin
        hz.StallF     = 1'b0;
        hz.StallD     = 1'b0;
        hz.StallE     = 1'b0;
        hz.StallM     = 1'b0;
        hz.FlushD     = 1'b0;
        hz.FlushE     = 1'b0;
        hz.FlushW     = 1'b0;
        hz.fwd_a_selE = FWD_RF;
        hz.fwd_b_selE = FWD_RF;
        if (i_rst_n) begin
            hz.fwd_a_selE = fwd_a;
            hz.fwd_b_selE = fwd_b;
            if (mem_wait) begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.StallE = 1'b1;
                hz.StallM = 1'b1;
                hz.FlushW = 1'b1;
            end else if (redirect) begin
                hz.FlushD = 1'b1;
                hz.FlushE = 1'b1;
            end else if (load_use) begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                hz.FlushE = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating counts of StallF cycles and redirect-driven flushes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hz.StallF && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redirect && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed cases followed by randomized
// traffic compared against a cycle-level behavioural model.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int unsigned T = 4;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_err;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl_if bus ();

    hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .hz          (bus.slave),
        .o_mem_err   (mem_err),
        .o_stall_cnt (stall_cnt),
        .o_flush_cnt (flush_cnt)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Model state: frozen cycles in the current wait episode, released flag,
    // sticky error and perf counters.
    int unsigned m_frozen;
    bit          m_rel;
    bit          m_err;
    logic [31:0] m_scnt, m_fcnt;
    bit          c_wait, c_sf, c_redir;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (bus.rd_wrenM && bus.rd_addrM != 0 && bus.rd_addrM == rs) return 2'd2;
        if (bus.rd_wrenW && bus.rd_addrW != 0 && bus.rd_addrW == rs) return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_reset();
        m_frozen = 0;
        m_rel    = 1'b0;
        m_err    = 1'b0;
        m_scnt   = '0;
        m_fcnt   = '0;
    endtask

    task automatic idle();
        bus.rs1_addrD = 0; bus.rs2_addrD = 0; bus.rs1_addrE = 0; bus.rs2_addrE = 0;
        bus.rd_addrE  = 0; bus.rd_wrenE  = 0; bus.wb_selE   = WB_ALU; bus.pc_selE = 0;
        bus.rd_addrM  = 0; bus.rd_wrenM  = 0; bus.rd_addrW  = 0; bus.rd_wrenW = 0;
        bus.lsu_req_M = 0; bus.lsu_ack_M = 0;
    endtask

    // Compare outputs at the falling edge, then advance the model on the rising edge.
    task automatic tick();
        logic [6:0] exp_ctl;
        bit lu;
        @(negedge clk);
        c_wait  = bus.lsu_req_M && !bus.lsu_ack_M && !m_rel;
        c_redir = !c_wait && bus.pc_selE;
        lu = bus.wb_selE == WB_MEM && bus.rd_wrenE && bus.rd_addrE != 0 &&
             (bus.rd_addrE == bus.rs1_addrD || bus.rd_addrE == bus.rs2_addrD);
        // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
        if (c_wait)       exp_ctl = 7'b1111_001;
        else if (c_redir) exp_ctl = 7'b0000_110;
        else if (lu)      exp_ctl = 7'b1100_010;
        else              exp_ctl = 7'b0000_000;
        c_sf = exp_ctl[6];
        check("ctl", {bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                      bus.FlushD, bus.FlushE, bus.FlushW}, exp_ctl);
        check("inv_stallE_flushE", bus.StallE & bus.FlushE, 0);
        check("fwd_a", bus.fwd_a_selE, ref_fwd(bus.rs1_addrE));
        check("fwd_b", bus.fwd_b_selE, ref_fwd(bus.rs2_addrE));
        check("mem_err", mem_err, m_err);
        check("stall_cnt", stall_cnt, m_scnt);
        check("flush_cnt", flush_cnt, m_fcnt);
        @(posedge clk);
        if (m_rel && (!bus.lsu_req_M || bus.lsu_ack_M)) m_rel = 1'b0;
        if (c_wait) begin
            m_frozen++;
            if (m_frozen == T) begin
                m_rel    = 1'b1;
                m_err    = 1'b1;
                m_frozen = 0;
            end
        end else begin
            m_frozen = 0;
        end
        if (PERF && c_sf && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
        if (PERF && c_redir && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
        #1;
    endtask

    initial begin
        idle();
        model_reset();
        #3;
        check("rst_ctl", {bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                          bus.FlushD, bus.FlushE, bus.FlushW}, 0);
        check("rst_err", mem_err, 0);
        #9 rst_n = 1'b1;

        // Forwarding: MEM beats WB, x0 in MEM falls back to WB.
        bus.rd_wrenM = 1; bus.rd_addrM = 5; bus.rs1_addrE = 5;
        bus.rd_wrenW = 1; bus.rd_addrW = 5;
        tick();
        check("fwd_mem_prio", bus.fwd_a_selE, 2'b10);
        bus.rd_addrM = 0;
        tick();
        idle();

        // Load-use: one bubble, then clear.
        bus.wb_selE = WB_MEM; bus.rd_wrenE = 1; bus.rd_addrE = 7; bus.rs2_addrD = 7;
        tick();
        idle();
        tick();

        // Redirect beats load-use.
        bus.wb_selE = WB_MEM; bus.rd_wrenE = 1; bus.rd_addrE = 7; bus.rs1_addrD = 7;
        bus.pc_selE = 1;
        tick();
        idle();

        // LSU ack after 3 stall cycles, with a redirect held behind the freeze.
        bus.lsu_req_M = 1; bus.pc_selE = 1;
        repeat (3) tick();
        bus.lsu_ack_M = 1;
        tick();
        idle();
        tick();

        // Timeout: freeze lasts T cycles, then released with error set.
        bus.lsu_req_M = 1;
        repeat (T + 3) tick();
        check("timeout_err", mem_err, 1);
        bus.lsu_req_M = 0;
        tick();
        bus.lsu_req_M = 1;
        tick();

        // Asynchronous reset in the middle of a wait.
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ctl", {bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                              bus.FlushD, bus.FlushE, bus.FlushW}, 0);
        check("rst_mid_err", mem_err, 0);
        check("rst_mid_scnt", stall_cnt, 0);
        model_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Randomized traffic over small register indices to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            bus.rs1_addrD = 5'($urandom_range(0, 3));
            bus.rs2_addrD = 5'($urandom_range(0, 3));
            bus.rs1_addrE = 5'($urandom_range(0, 3));
            bus.rs2_addrE = 5'($urandom_range(0, 3));
            bus.rd_addrE  = 5'($urandom_range(0, 3));
            bus.rd_addrM  = 5'($urandom_range(0, 3));
            bus.rd_addrW  = 5'($urandom_range(0, 3));
            bus.rd_wrenE  = 1'($urandom);
            bus.rd_wrenM  = 1'($urandom);
            bus.rd_wrenW  = 1'($urandom);
            bus.wb_selE   = 2'($urandom);
            bus.pc_selE   = ($urandom_range(0, 4) == 0);
            if (bus.lsu_req_M) bus.lsu_req_M = ($urandom_range(0, 9) != 0);
            else               bus.lsu_req_M = ($urandom_range(0, 3) == 0);
            bus.lsu_ack_M = bus.lsu_req_M && ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
